keypad_scanner: RTL
===================

KEYPAD_SCANNER -- requirements
Module: keypad_scanner

Interface
REQ-001 The block SHALL have parameter SCAN_DIV, default 49999, meaning scan tick period minus one, in clkin cycles.
REQ-002 The block SHALL have parameter DEBOUNCE_TICKS, default 4, meaning the number of consecutive stable ticks required for press and for release.
REQ-003 The block SHALL have port clkin, input, 1 bit: system clock, 100 MHz nominal.
REQ-004 The block SHALL have port reset, input, 1 bit: reset, asynchronous, active-high; clock clkin.
REQ-005 The block SHALL have port row, input, 4 bits: keypad row lines, active-low, externally pulled up, asynchronous to clkin.
REQ-006 The block SHALL have port col, output, 4 bits: keypad column drive, active-low, at most one bit low at any time.
REQ-007 The block SHALL have port key_code, output, 4 bits: {row_idx[1:0], col_idx[1:0]} of the last accepted key.
REQ-008 The block SHALL have port key_valid, output, 1 bit: one-clkin-cycle pulse when a press is accepted.
REQ-009 The block SHALL have port key_held, output, 1 bit: high while an accepted key remains pressed.

Function
REQ-010 row SHALL pass through a 2-flop synchronizer (reset value 4'b1111); all decisions SHALL use the synchronized value only.
REQ-011 A free-running tick counter SHALL count 0..SCAN_DIV and then wrap to 0; tick SHALL be high for exactly the one cycle in which the count equals SCAN_DIV.
REQ-012 col SHALL equal ~(4'b0001 << col_idx): 1110, 1101, 1011, 0111 for col_idx 0..3.
REQ-013 FSM states SHALL be SCAN, DEBOUNCE, HELD and RELEASE; all state, counter and column transitions SHALL occur only on tick cycles, except the clearing of key_valid.
REQ-014 In SCAN, on tick with synchronized row == 4'b1111, col_idx SHALL increment modulo 4 (3 -> 0 wrap).
REQ-015 In SCAN, on tick with any row bit low, the block SHALL latch row_idx = lowest-index low bit, keep col_idx frozen, set deb_cnt = 1, and go to DEBOUNCE.
REQ-016 In DEBOUNCE, on tick with row bit row_idx still low, deb_cnt SHALL increment; when deb_cnt reaches DEBOUNCE_TICKS, the block SHALL go to HELD.
REQ-017 On the DEBOUNCE -> HELD transition, key_code SHALL update to {row_idx, col_idx} and key_valid SHALL be high for that same single cycle only.
REQ-018 In DEBOUNCE, on tick with row bit row_idx high (bounce), deb_cnt SHALL clear, col_idx SHALL advance modulo 4, and the block SHALL return to SCAN with no key_valid.
REQ-019 In HELD, key_held SHALL be 1; on tick with row bit row_idx high, the block SHALL go to RELEASE with deb_cnt = 1; otherwise it SHALL stay in HELD with no auto-repeat.
REQ-020 In RELEASE, key_held SHALL remain 1.
REQ-021 In RELEASE, on tick with row bit row_idx high, deb_cnt SHALL increment; at DEBOUNCE_TICKS the block SHALL clear key_held, advance col_idx, and go to SCAN.
REQ-022 In RELEASE, on tick with row bit row_idx low, the block SHALL return to HELD with no new key_valid.
REQ-023 While in DEBOUNCE, HELD or RELEASE, other row bits and other columns SHALL be ignored (no rollover); a second key SHALL be detected only after returning to SCAN.
REQ-024 Simultaneous presses in one column SHALL resolve to the lowest row index.
REQ-025 key_code SHALL hold its last value until the next accepted press.
REQ-026 Press-to-key_valid latency SHALL be at most (4 + DEBOUNCE_TICKS) ticks plus 3 clkin cycles.

Reset
REQ-027 On reset assertion, the block SHALL immediately set col = 4'b1110, key_code = 0, key_valid = 0, key_held = 0, state = SCAN, col_idx = 0, deb_cnt = 0, tick counter = 0, and synchronizer = 4'b1111.
REQ-028 Reset asserted mid-DEBOUNCE or mid-HELD SHALL abort the operation with no key_valid pulse; after release, scanning SHALL restart at column 0.

Verification (bench parameters SCAN_DIV=3, DEBOUNCE_TICKS=2)
REQ-029 Scenario: after reset with no keys pressed, 16 ticks -> col cycles 1110, 1101, 1011, 0111 four times, each column held for 4 clkin cycles; key_valid never asserts.
REQ-030 Scenario: model drives row[2] low whenever col == 1011, held steady -> exactly one key_valid pulse with key_code = 4'b1010 and key_held = 1; col stays frozen at 1011.
REQ-031 Scenario: key at row 1 / col 3 that bounces high on the tick after detection -> no key_valid; scanning resumes with col = 1110.
REQ-032 Scenario: release a held key, then re-press it after one tick -> no second key_valid, key_held stays 1; full release for 2 ticks -> key_held = 0 and scanning resumes.
REQ-033 Scenario: rows 0 and 3 pressed together in col 0 -> key_code = 4'b0000; a key in col 2 pressed while col 0 is held is ignored until release.
REQ-034 Scenario: reset pulse while in DEBOUNCE -> no key_valid, all outputs at their reset values, scanning restarts at col = 1110.

Source files
------------

// File: rtl/keypad_scanner_if.sv
// Keypad matrix connection: row sense lines in, column drive and decoded key status out.
interface keypad_scanner_if;
  logic [3:0] row;
  logic [3:0] col;
  logic [3:0] key_code;
  logic       key_valid;
  logic       key_held;

  modport master (
    output row,
    input  col,
    input  key_code,
    input  key_valid,
    input  key_held
  );

  modport slave (
    input  row,
    output col,
    output key_code,
    output key_valid,
    output key_held
  );
endinterface

// File: rtl/keypad_scanner.sv
// 4x4 keypad scanner: walks one active-low column per scan tick, debounces
// the first key seen in that column, reports it once and waits for release.
module keypad_scanner #(
  parameter int SCAN_DIV       = 49999,
  parameter int DEBOUNCE_TICKS = 4
) (
  input  logic            clkin,
  input  logic            reset,
  keypad_scanner_if.slave kp
);

  localparam int TW = (SCAN_DIV > 0) ? $clog2(SCAN_DIV + 1) : 1;
  // Counter must reach DEBOUNCE_TICKS and its increment must not wrap.
  localparam int DW = $clog2(DEBOUNCE_TICKS + 2);

  typedef enum logic [1:0] {
    SCAN     = 2'd0,
    DEBOUNCE = 2'd1,
    HELD     = 2'd2,
    RELEASE  = 2'd3
  } state_t;

  state_t          state_q, state_d;
  logic [TW-1:0]   tick_cnt_q, tick_cnt_d;
  logic [3:0]      row_meta_q, row_meta_d;
  logic [3:0]      row_sync_q, row_sync_d;
  logic [1:0]      col_idx_q, col_idx_d;
  logic [1:0]      row_idx_q, row_idx_d;
  logic [DW-1:0]   deb_cnt_q, deb_cnt_d;
  logic [3:0]      key_code_q, key_code_d;
  logic            key_valid_q, key_valid_d;
  logic            key_held_q, key_held_d;
  logic [3:0]      col_q, col_d;

  logic            tick_s;
  logic            row_down_s;
  logic [DW-1:0]   deb_inc_s;
  logic            deb_done_s;

  // Lowest-index active-low row bit; simultaneous presses resolve to the lowest row.
  function automatic logic [1:0] lowest_low(input logic [3:0] r);
    logic [1:0] idx;
    if (r[0] == 1'b0) begin
      idx = 2'd0;
    end else if (r[1] == 1'b0) begin
      idx = 2'd1;
    end else if (r[2] == 1'b0) begin
      idx = 2'd2;
    end else begin
      idx = 2'd3;
    end
    return idx;
  endfunction

  assign tick_s     = (tick_cnt_q == TW'(SCAN_DIV));
  assign row_down_s = (row_sync_q[row_idx_q] == 1'b0);
  assign deb_inc_s  = deb_cnt_q + DW'(1);
  assign deb_done_s = (deb_inc_s >= DW'(DEBOUNCE_TICKS));

  // Scan tick divider and two-stage row synchronizer.
  always_comb begin
    if (tick_s) begin
      tick_cnt_d = '0;
    end else begin
      tick_cnt_d = tick_cnt_q + TW'(1);
    end
    row_meta_d = kp.row;
    row_sync_d = row_meta_q;
  end

  // Scan/debounce FSM next state; everything but the key_valid clear moves on ticks only.
  always_comb begin
    state_d     = state_q;
    col_idx_d   = col_idx_q;
    row_idx_d   = row_idx_q;
    deb_cnt_d   = deb_cnt_q;
    key_code_d  = key_code_q;
    key_valid_d = 1'b0;
    if (tick_s) begin
      case (state_q)
        SCAN: begin
          if (row_sync_q == 4'b1111) begin
            col_idx_d = col_idx_q + 2'd1;
          end else begin
            row_idx_d = lowest_low(row_sync_q);
            deb_cnt_d = DW'(1);
            state_d   = DEBOUNCE;
          end
        end
        DEBOUNCE: begin
          if (row_down_s) begin
            deb_cnt_d = deb_inc_s;
            if (deb_done_s) begin
              state_d     = HELD;
              key_code_d  = {row_idx_q, col_idx_q};
              key_valid_d = 1'b1;
            end else begin
              state_d = DEBOUNCE;
            end
          end else begin
            // Bounce: drop the candidate and move on to the next column.
            deb_cnt_d = '0;
            col_idx_d = col_idx_q + 2'd1;
            state_d   = SCAN;
          end
        end
        HELD: begin
          if (row_down_s) begin
            state_d = HELD;
          end else begin
            deb_cnt_d = DW'(1);
            state_d   = RELEASE;
          end
        end
        RELEASE: begin
          if (row_down_s) begin
            // Key came back before release was confirmed: no new report.
            deb_cnt_d = '0;
            state_d   = HELD;
          end else begin
            deb_cnt_d = deb_inc_s;
            if (deb_done_s) begin
              deb_cnt_d = '0;
              col_idx_d = col_idx_q + 2'd1;
              state_d   = SCAN;
            end else begin
              state_d = RELEASE;
            end
          end
        end
        default: begin
          state_d = SCAN;
        end
      endcase
    end else begin
      state_d = state_q;
    end
    key_held_d = (state_d == HELD) || (state_d == RELEASE);
    col_d      = ~(4'b0001 << col_idx_d);
  end

  // State and output registers with asynchronous reset to the idle scan of column 0.
  always_ff @(posedge clkin or posedge reset) begin
    if (reset) begin
      state_q     <= SCAN;
      tick_cnt_q  <= '0;
      row_meta_q  <= 4'b1111;
      row_sync_q  <= 4'b1111;
      col_idx_q   <= 2'd0;
      row_idx_q   <= 2'd0;
      deb_cnt_q   <= '0;
      key_code_q  <= 4'd0;
      key_valid_q <= 1'b0;
      key_held_q  <= 1'b0;
      col_q       <= 4'b1110;
    end else begin
      state_q     <= state_d;
      tick_cnt_q  <= tick_cnt_d;
      row_meta_q  <= row_meta_d;
      row_sync_q  <= row_sync_d;
      col_idx_q   <= col_idx_d;
      row_idx_q   <= row_idx_d;
      deb_cnt_q   <= deb_cnt_d;
      key_code_q  <= key_code_d;
      key_valid_q <= key_valid_d;
      key_held_q  <= key_held_d;
      col_q       <= col_d;
    end
  end

  assign kp.col       = col_q;
  assign kp.key_code  = key_code_q;
  assign kp.key_valid = key_valid_q;
  assign kp.key_held  = key_held_q;

endmodule
